// File: rtl/nw_seq_reader.sv
// nw_seq_reader: AXI read engine and byte unpacker for the NW core sequence input.
// Optional perf counters are compiled in when NW_SEQ_READER_PERF_EN is defined.
module nw_seq_reader #(
  parameter int DATA_W     = 512,
  parameter int ADDR_W     = 64,
  parameter int ID_W       = 16,
  parameter int AR_ID      = 0,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [31:0]       start_len,
  output logic [ID_W-1:0]   arid_m,
  output logic [ADDR_W-1:0] araddr_m,
  output logic [7:0]        arlen_m,
  output logic [2:0]        arsize_m,
  output logic              arvalid_m,
  input  logic              arready_m,
  input  logic [ID_W-1:0]   rid_m,
  input  logic [DATA_W-1:0] rdata_m,
  input  logic [1:0]        rresp_m,
  input  logic              rlast_m,
  input  logic              rvalid_m,
  output logic              rready_m,
  output logic              char_valid,
  input  logic              char_ready,
  output logic [7:0]        char_data,
  output logic              char_last,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic [1:0]        state_dbg
`ifdef NW_SEQ_READER_PERF_EN
  ,
  output logic [31:0]       perf_busy_cycles,
  output logic [31:0]       perf_stall_cycles
`endif
);

  // Every channel uses valid/ready: a transfer happens on a rising edge where both
  // are high, and the sender holds valid and payload stable until that edge.

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, araddr_q;
  logic [31:0]       beats_rem_q, chars_left_q;
  logic [CNT_W-1:0]  outstanding_q, count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [DATA_W-1:0] head;
  logic [5:0]        byte_idx_q;
  logic [7:0]        arlen_q, cdata_q;
  logic [8:0]        burst_l;
  logic              arvalid_q, rready_q, cvalid_q, clast_q;
  logic              done_q, busy_q, err_q, ready_q;
  logic              ready_d, busy_d, done_d;
  logic              accept, ar_hs, r_hs, c_hs, load, pop, raise_ar;
  logic [31:0]       to_4k, burst, free_slots;
  logic              unused_ok;

  assign unused_ok = ^{rid_m, rlast_m};

  assign accept  = (state_q == S_IDLE) && start_valid && ready_q;
  assign ar_hs   = arvalid_q && arready_m;
  assign r_hs    = rvalid_m && rready_q;
  assign c_hs    = cvalid_q && char_ready;
  assign burst_l = {1'b0, arlen_q} + 9'd1;
  assign head    = mem[rd_ptr_q];

  // Burst size is the smallest of the beat cap, remaining beats and beats to the 4 KB line.
  always_comb begin
    to_4k = 32'd64 - {26'd0, addr_q[11:6]};
    burst = beats_rem_q;
    if (burst > 32'(MAX_BURST)) burst = 32'(MAX_BURST);
    if (burst > to_4k) burst = to_4k;
    free_slots = 32'(FIFO_DEPTH) - {{(32-CNT_W){1'b0}}, count_q}
                 - {{(32-CNT_W){1'b0}}, outstanding_q};
  end

  // Credit: only request beats the FIFO is guaranteed to absorb, so rready never stalls.
  assign raise_ar = (state_q == S_ISSUE) && !arvalid_q && (beats_rem_q != 32'd0)
                    && (free_slots >= burst);

  assign load = (state_q != S_IDLE) && (count_q != '0) && (chars_left_q != 32'd0)
                && (!cvalid_q || char_ready);
  assign pop  = load && ((byte_idx_q == 6'd63) || (chars_left_q == 32'd1));
  assign count_d = count_q + CNT_W'(r_hs) - CNT_W'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && (start_len != 32'd0)) state_d = S_ISSUE;
      S_ISSUE: if (ar_hs && (beats_rem_q == {23'd0, burst_l})) state_d = S_DRAIN;
      S_DRAIN: if (c_hs && clast_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (accept && (start_len == 32'd0)) || ((state_q == S_DRAIN) && c_hs && clast_q);
  end

  always_ff @(posedge clk) begin
    if (r_hs) mem[wr_ptr_q] <= rdata_m;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      addr_q        <= '0;
      araddr_q      <= '0;
      arlen_q       <= '0;
      arvalid_q     <= 1'b0;
      beats_rem_q   <= '0;
      chars_left_q  <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rready_q      <= 1'b0;
      byte_idx_q    <= '0;
      cvalid_q      <= 1'b0;
      clast_q       <= 1'b0;
      cdata_q       <= '0;
    end else begin
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;

      if (accept) begin
        addr_q       <= start_addr;
        beats_rem_q  <= 32'(({1'b0, start_len} + 33'd63) >> 6);
        chars_left_q <= start_len;
        byte_idx_q   <= '0;
      end

      if (raise_ar) begin
        arvalid_q <= 1'b1;
        arlen_q   <= 8'(burst - 32'd1);
        araddr_q  <= addr_q;
      end else if (ar_hs) begin
        arvalid_q   <= 1'b0;
        addr_q      <= addr_q + {{(ADDR_W-15){1'b0}}, burst_l, 6'd0};
        beats_rem_q <= beats_rem_q - {23'd0, burst_l};
      end
      outstanding_q <= outstanding_q + (ar_hs ? CNT_W'(burst_l) : '0) - CNT_W'(r_hs);

      if (r_hs) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (rresp_m != 2'b00) err_q <= 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_d;
      rready_q <= (count_d != CNT_W'(FIFO_DEPTH));

      // Output register refills whenever it is empty or being consumed this cycle.
      if (load) begin
        cvalid_q     <= 1'b1;
        cdata_q      <= head[{byte_idx_q, 3'b000} +: 8];
        clast_q      <= (chars_left_q == 32'd1);
        chars_left_q <= chars_left_q - 32'd1;
        byte_idx_q   <= pop ? 6'd0 : byte_idx_q + 6'd1;
      end else if (c_hs) begin
        cvalid_q <= 1'b0;
        clast_q  <= 1'b0;
      end
    end
  end

`ifdef NW_SEQ_READER_PERF_EN
  logic [31:0] perf_busy_q, perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else if (accept) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy_q && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 32'd1;
      if (cvalid_q && !char_ready && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_busy_cycles  = perf_busy_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

  assign start_ready = ready_q;
  assign arid_m      = ID_W'(AR_ID);
  assign araddr_m    = araddr_q;
  assign arlen_m     = arlen_q;
  assign arsize_m    = 3'd6;
  assign arvalid_m   = arvalid_q;
  assign rready_m    = rready_q;
  assign char_valid  = cvalid_q;
  assign char_data   = cdata_q;
  assign char_last   = clast_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign state_dbg   = state_q;

endmodule
